sdr_rom_arbiter: RTL and testbench

- Shares one SDRAM ROM read port among the layer graphics fetchers (channel 0 = OBJ, 1 = BACK1, 2 = BACK2).
- Sits between the OBJ/BACK1/BACK2 fetchers and the SDRAM controller, replacing the three separate sdr_obj/bg1/bg2 ports.
- Arbitration is round-robin.
- Each channel has a one-entry last-address cache, so repeated fetches are answered without an SDRAM access.
- A watchdog aborts a stalled SDRAM access.

---
 rtl/sdr_rom_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sdr_rom_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_rom_arbiter.sv
// Round-robin arbiter sharing one SDRAM ROM read port among the layer fetchers.
// It keeps a one-entry last-address cache per channel and a watchdog that aborts stalled SDRAM reads.
module sdr_rom_arbiter #(
  parameter int NCH      = 3,
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter int TIMEOUT  = 255,
  parameter int CACHE_EN = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH-1:0]    ch_req,
  output logic [NCH-1:0]    ch_rdy,
  output logic [DW-1:0]     ch_dout,
  output logic [AW-1:0]     sdr_addr,
  output logic              sdr_req,
  input  logic              sdr_rdy,
  input  logic [DW-1:0]     sdr_dout,
  input  logic              cache_inv,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [AW-1:0]     sdr_addr_q, sdr_addr_d;
  logic              sdr_req_q, sdr_req_d;
  logic [NCH-1:0]    ch_rdy_q, ch_rdy_d;
  logic [DW-1:0]     ch_dout_q, ch_dout_d;
  logic              timeout_err_q, timeout_err_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic              drain_q, drain_d;
  logic              kill_q, kill_d;
  logic [NCH-1:0]    valid_q, valid_d;
  logic [AW-1:0]     tag_q  [NCH];
  logic [AW-1:0]     tag_d  [NCH];
  logic [DW-1:0]     data_q [NCH];
  logic [DW-1:0]     data_d [NCH];

  logic [NCH-1:0]    holdoff;
  logic [NCH-1:0]    eligible;
  logic [PW-1:0]     win;
  logic              win_found;
  logic [AW-1:0]     win_addr;
  logic              hit;
  int                idx;

  // A channel is masked while its completion pulse is out, so a request the
  // requester has not yet had a chance to drop or re-address is not served twice.
  assign holdoff  = ch_rdy_q;
  assign eligible = ch_req & ~holdoff;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!win_found && eligible[idx]) begin
        win       = PW'(idx);
        win_found = 1'b1;
      end
    end
  end

  assign win_addr = ch_addr[int'(win)*AW +: AW];
  assign hit      = (CACHE_EN != 0) && valid_q[win] && (tag_q[win] == win_addr) && !cache_inv;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    sdr_addr_d    = sdr_addr_q;
    sdr_req_d     = sdr_req_q;
    ch_rdy_d      = '0;
    ch_dout_d     = ch_dout_q;
    timeout_err_d = timeout_err_q & ~err_clr;
    wdog_d        = wdog_q;
    drain_d       = drain_q;
    kill_d        = kill_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    data_d        = data_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          if (hit) begin
            ch_rdy_d[win] = 1'b1;
            ch_dout_d     = data_q[win];
            ptr_d         = win;
          end else begin
            gnt_d      = win;
            sdr_addr_d = win_addr;
            sdr_req_d  = 1'b1;
            wdog_d     = '0;
            kill_d     = 1'b0;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        // sdr_rdy takes priority over a watchdog expiry in the same cycle.
        if (sdr_rdy) begin
          sdr_req_d       = 1'b0;
          ch_rdy_d[gnt_q] = 1'b1;
          ch_dout_d       = sdr_dout;
          ptr_d           = gnt_q;
          state_d         = IDLE;
          if (!kill_q && !cache_inv) begin
            valid_d[gnt_q] = 1'b1;
            tag_d[gnt_q]   = sdr_addr_q;
            data_d[gnt_q]  = sdr_dout;
          end
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          sdr_req_d       = 1'b0;
          timeout_err_d   = 1'b1;
          ch_rdy_d[gnt_q] = 1'b1;
          ch_dout_d       = '1;
          ptr_d           = gnt_q;
          wdog_d          = wdog_q + 1'b1;
          drain_d         = 1'b0;
          state_d         = DRAIN;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
        if (cache_inv) kill_d = 1'b1;
      end
      DRAIN: begin
        if (sdr_rdy || drain_q) state_d = IDLE;
        else                    drain_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (cache_inv) valid_d = '0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      ptr_q         <= PW'(NCH - 1);
      gnt_q         <= '0;
      sdr_addr_q    <= '0;
      sdr_req_q     <= 1'b0;
      ch_rdy_q      <= '0;
      ch_dout_q     <= '0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
      drain_q       <= 1'b0;
      kill_q        <= 1'b0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      sdr_addr_q    <= sdr_addr_d;
      sdr_req_q     <= sdr_req_d;
      ch_rdy_q      <= ch_rdy_d;
      ch_dout_q     <= ch_dout_d;
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
      drain_q       <= drain_d;
      kill_q        <= kill_d;
      valid_q       <= valid_d;
    end
  end

  // Cache tags and data are only meaningful behind valid_q, so they need no reset.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign ch_rdy      = ch_rdy_q;
  assign ch_dout     = ch_dout_q;
  assign sdr_addr    = sdr_addr_q;
  assign sdr_req     = sdr_req_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdr_rom_arbiter.sv
// Directed testbench for sdr_rom_arbiter: a cached instance with a short watchdog,
// and an uncached instance used for the holdoff scenario.
module tb_sdr_rom_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 25;
  localparam int DW  = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              RSTn;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_req;
  logic [NCH-1:0]    ch_rdy;
  logic [DW-1:0]     ch_dout;
  logic [AW-1:0]     sdr_addr;
  logic              sdr_req;
  logic              sdr_rdy;
  logic [DW-1:0]     sdr_dout;
  logic              cache_inv;
  logic              timeout_err;
  logic              err_clr;

  logic [NCH*AW-1:0] h_addr;
  logic [NCH-1:0]    h_req;
  logic [NCH-1:0]    h_rdy;
  logic [DW-1:0]     h_dout;
  logic [AW-1:0]     h_sdr_addr;
  logic              h_sdr_req;
  logic              h_sdr_rdy;
  logic [DW-1:0]     h_sdr_dout;
  logic              h_inv;
  logic              h_terr;
  logic              h_clr;

  int checks = 0;
  int errors = 0;
  int sreq_rises = 0;

  sdr_rom_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(8), .CACHE_EN(1)) u_dut (
    .CLK(CLK), .RSTn(RSTn), .ch_addr(ch_addr), .ch_req(ch_req), .ch_rdy(ch_rdy),
    .ch_dout(ch_dout), .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_rdy(sdr_rdy),
    .sdr_dout(sdr_dout), .cache_inv(cache_inv), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  sdr_rom_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(8), .CACHE_EN(0)) u_nc (
    .CLK(CLK), .RSTn(RSTn), .ch_addr(h_addr), .ch_req(h_req), .ch_rdy(h_rdy),
    .ch_dout(h_dout), .sdr_addr(h_sdr_addr), .sdr_req(h_sdr_req), .sdr_rdy(h_sdr_rdy),
    .sdr_dout(h_sdr_dout), .cache_inv(h_inv), .timeout_err(h_terr), .err_clr(h_clr)
  );

  always @(posedge sdr_req) sreq_rises++;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    ch_addr[ch*AW +: AW] = a;
  endtask

  task automatic wait_sreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sdr_req) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic do_reset;
    RSTn = 1'b0;
    ch_req = '0; ch_addr = '0; sdr_rdy = 1'b0; sdr_dout = '0; cache_inv = 1'b0; err_clr = 1'b0;
    h_req = '0; h_addr = '0; h_sdr_rdy = 1'b0; h_sdr_dout = '0; h_inv = 1'b0; h_clr = 1'b0;
    tick(); tick();
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (ch_rdy !== 3'b000) begin errors++; $display("FAIL reset_ch_rdy: got %b expected 000", ch_rdy); end
    checks++; if (ch_dout !== 16'h0000) begin errors++; $display("FAIL reset_ch_dout: got %h expected 0000", ch_dout); end
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL reset_sdr_req: got %b expected 0", sdr_req); end
    checks++; if (sdr_addr !== 25'h0) begin errors++; $display("FAIL reset_sdr_addr: got %h expected 0", sdr_addr); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
  endtask

  task automatic test_single_miss;
    bit ok;
    int r0;
    r0 = sreq_rises;
    set_addr(0, 25'h0001234);
    ch_req = 3'b001;
    wait_sreq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL miss_sdr_req: got none expected sdr_req within 20 cycles"); end
    checks++; if (sdr_addr !== 25'h0001234) begin errors++; $display("FAIL miss_sdr_addr: got %h expected 0001234", sdr_addr); end
    repeat (5) tick();
    sdr_rdy = 1'b1; sdr_dout = 16'hBEEF;
    tick();
    sdr_rdy = 1'b0;
    checks++; if (ch_rdy !== 3'b001) begin errors++; $display("FAIL miss_ch_rdy: got %b expected 001", ch_rdy); end
    checks++; if (ch_dout !== 16'hBEEF) begin errors++; $display("FAIL miss_ch_dout: got %h expected beef", ch_dout); end
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL miss_sdr_req_drop: got %b expected 0", sdr_req); end
    tick();
    checks++; if (ch_rdy !== 3'b000 || ch_dout !== 16'hBEEF) begin errors++; $display("FAIL miss_hold: got rdy %b dout %h expected 000 beef", ch_rdy, ch_dout); end
    ch_req = 3'b000;
    repeat (3) tick();
    checks++; if (sreq_rises - r0 !== 1) begin errors++; $display("FAIL miss_one_access: got %0d expected 1", sreq_rises - r0); end
  endtask

  task automatic test_cache_hit;
    bit ok;
    int r0;
    r0 = sreq_rises;
    ch_req = 3'b001;
    tick();
    checks++; if (ch_rdy !== 3'b001 || ch_dout !== 16'hBEEF) begin errors++; $display("FAIL hit_data: got rdy %b dout %h expected 001 beef", ch_rdy, ch_dout); end
    checks++; if (sdr_req !== 1'b0) begin errors++; $display("FAIL hit_no_sdr: got %b expected 0", sdr_req); end
    tick();
    ch_req = 3'b000;
    tick();
    checks++; if (sreq_rises !== r0) begin errors++; $display("FAIL hit_no_access: got %0d expected %0d", sreq_rises, r0); end
    // Invalidate, then the same address must go to SDRAM.
    cache_inv = 1'b1;
    tick();
    cache_inv = 1'b0;
    ch_req = 3'b001;
    wait_sreq(ok);
    checks++; if (!ok || sreq_rises !== r0 + 1) begin errors++; $display("FAIL inv_miss: got ok %0d rises %0d expected 1 %0d", ok, sreq_rises, r0 + 1); end
    sdr_rdy = 1'b1; sdr_dout = 16'h5A5A;
    tick();
    sdr_rdy = 1'b0;
    checks++; if (ch_rdy !== 3'b001 || ch_dout !== 16'h5A5A) begin errors++; $display("FAIL inv_fill: got rdy %b dout %h expected 001 5a5a", ch_rdy, ch_dout); end
    tick();
    ch_req = 3'b000;
    tick();
    // cache_inv coinciding with the hit decision forces a miss.
    ch_req = 3'b001; cache_inv = 1'b1;
    tick();
    cache_inv = 1'b0;
    checks++; if (ch_rdy !== 3'b000 || sdr_req !== 1'b1) begin errors++; $display("FAIL inv_same_cycle: got rdy %b sdr_req %b expected 000 1", ch_rdy, sdr_req); end
    // cache_inv while waiting discards the in-flight fill.
    cache_inv = 1'b1;
    tick();
    cache_inv = 1'b0;
    sdr_rdy = 1'b1; sdr_dout = 16'h6666;
    tick();
    sdr_rdy = 1'b0;
    checks++; if (ch_rdy !== 3'b001 || ch_dout !== 16'h6666) begin errors++; $display("FAIL inv_wait_data: got rdy %b dout %h expected 001 6666", ch_rdy, ch_dout); end
    tick();
    ch_req = 3'b000;
    tick();
    ch_req = 3'b001;
    tick();
    checks++; if (ch_rdy !== 3'b000 || sdr_req !== 1'b1) begin errors++; $display("FAIL inv_wait_nofill: got rdy %b sdr_req %b expected 000 1", ch_rdy, sdr_req); end
    sdr_rdy = 1'b1; sdr_dout = 16'h7777;
    tick();
    sdr_rdy = 1'b0;
    tick();
    ch_req = 3'b000;
    tick();
  endtask

  task automatic test_round_robin;
    bit ok;
    int exp_ch;
    int rnd;
    logic [AW-1:0] exp_a;
    logic [NCH-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < NCH; c++) set_addr(c, 25'h0100000 * (c + 1));
    ch_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_ch = k % 3;
      rnd = k / 3;
      exp_a = 25'h0100000 * (exp_ch + 1) + rnd;
      exp_rdy = 3'b001 << exp_ch;
      wait_sreq(ok);
      checks++; if (!ok || sdr_addr !== exp_a) begin errors++; $display("FAIL rr_grant%0d: got ok %0d addr %h expected %h", k, ok, sdr_addr, exp_a); end
      tick(); tick();
      sdr_rdy = 1'b1; sdr_dout = 16'hA000 + 16'(k);
      tick();
      sdr_rdy = 1'b0;
      checks++; if (ch_rdy !== exp_rdy || ch_dout !== 16'hA000 + 16'(k)) begin errors++; $display("FAIL rr_done%0d: got rdy %b dout %h expected %b %h", k, ch_rdy, ch_dout, exp_rdy, 16'hA000 + 16'(k)); end
      if (k == 5) ch_req = 3'b000;
      tick();
      if (k < 5) set_addr(exp_ch, exp_a + 25'h1);
    end
    tick();
  endtask

  task automatic test_timeout;
    bit ok;
    bit held;
    set_addr(1, 25'h00ABCDE);
    ch_req = 3'b010;
    wait_sreq(ok);
    held = ok;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (!sdr_req) held = 1'b0;
    end
    checks++; if (!held) begin errors++; $display("FAIL to_req_held: got dropped expected 8 cycles of sdr_req"); end
    tick();
    checks++; if (sdr_req !== 1'b0 || ch_rdy !== 3'b010) begin errors++; $display("FAIL to_abort: got sdr_req %b rdy %b expected 0 010", sdr_req, ch_rdy); end
    checks++; if (ch_dout !== 16'hFFFF || timeout_err !== 1'b1) begin errors++; $display("FAIL to_data_flag: got dout %h err %b expected ffff 1", ch_dout, timeout_err); end
    sdr_rdy = 1'b1; sdr_dout = 16'h1111;
    tick();
    sdr_rdy = 1'b0;
    ch_req = 3'b000;
    checks++; if (ch_rdy !== 3'b000 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_drain: got rdy %b err %b expected 000 1", ch_rdy, timeout_err); end
    tick(); tick();
    ch_req = 3'b010;
    tick();
    checks++; if (sdr_req !== 1'b1 || ch_rdy !== 3'b000) begin errors++; $display("FAIL to_no_fill: got sdr_req %b rdy %b expected 1 000", sdr_req, ch_rdy); end
    sdr_rdy = 1'b1; sdr_dout = 16'h3333;
    tick();
    sdr_rdy = 1'b0;
    checks++; if (ch_rdy !== 3'b010 || ch_dout !== 16'h3333 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got rdy %b dout %h err %b expected 010 3333 1", ch_rdy, ch_dout, timeout_err); end
    tick();
    ch_req = 3'b000;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b expected 0", timeout_err); end
    // sdr_rdy on the final watchdog cycle completes normally.
    set_addr(2, 25'h00F0F0F);
    ch_req = 3'b100;
    wait_sreq(ok);
    repeat (7) tick();
    sdr_rdy = 1'b1; sdr_dout = 16'h2222;
    tick();
    sdr_rdy = 1'b0;
    checks++; if (!ok || ch_rdy !== 3'b100 || ch_dout !== 16'h2222 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_race: got rdy %b dout %h err %b expected 100 2222 0", ch_rdy, ch_dout, timeout_err); end
    tick();
    ch_req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_access;
    bit ok;
    set_addr(0, 25'h0004444);
    ch_req = 3'b001;
    wait_sreq(ok);
    sdr_rdy = 1'b1; sdr_dout = 16'h4040;
    tick();
    sdr_rdy = 1'b0;
    tick();
    ch_req = 3'b000;
    tick();
    set_addr(1, 25'h0005555);
    ch_req = 3'b010;
    wait_sreq(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_setup: got no sdr_req expected one"); end
    #2 RSTn = 1'b0;
    #1;
    checks++; if (sdr_req !== 1'b0 || sdr_addr !== 25'h0) begin errors++; $display("FAIL rst_async_sdr: got req %b addr %h expected 0 0", sdr_req, sdr_addr); end
    checks++; if (ch_rdy !== 3'b000 || ch_dout !== 16'h0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rst_async_ch: got rdy %b dout %h err %b expected 000 0000 0", ch_rdy, ch_dout, timeout_err); end
    ch_req = 3'b000;
    tick();
    RSTn = 1'b1;
    tick();
    sdr_rdy = 1'b1; sdr_dout = 16'h9999;
    tick();
    sdr_rdy = 1'b0;
    checks++; if (ch_rdy !== 3'b000 || sdr_req !== 1'b0) begin errors++; $display("FAIL rst_late_rdy: got rdy %b req %b expected 000 0", ch_rdy, sdr_req); end
    ch_req = 3'b001;
    tick();
    checks++; if (sdr_req !== 1'b1 || ch_rdy !== 3'b000) begin errors++; $display("FAIL rst_cache_cleared: got req %b rdy %b expected 1 000", sdr_req, ch_rdy); end
    sdr_rdy = 1'b1; sdr_dout = 16'h4141;
    tick();
    sdr_rdy = 1'b0;
    tick();
    ch_req = 3'b000;
    tick();
  endtask

  task automatic test_holdoff;
    int n;
    do_reset();
    h_addr[1*AW +: AW] = 25'h0000777;
    h_req = 3'b010;
    n = 0;
    while (!h_sdr_req && n < 20) begin tick(); n++; end
    h_sdr_rdy = 1'b1; h_sdr_dout = 16'h7070;
    tick();
    h_sdr_rdy = 1'b0;
    checks++; if (h_rdy !== 3'b010 || h_dout !== 16'h7070) begin errors++; $display("FAIL ho_first: got rdy %b dout %h expected 010 7070", h_rdy, h_dout); end
    tick();
    checks++; if (h_sdr_req !== 1'b0) begin errors++; $display("FAIL ho_masked: got sdr_req %b expected 0", h_sdr_req); end
    n = 1;
    while (!h_sdr_req && n < 20) begin tick(); n++; end
    checks++; if (h_sdr_req !== 1'b1 || n < 2 || h_sdr_addr !== 25'h0000777) begin errors++; $display("FAIL ho_second: got req %b after %0d cycles addr %h expected 1 >=2 0000777", h_sdr_req, n, h_sdr_addr); end
    h_sdr_rdy = 1'b1; h_sdr_dout = 16'h7171;
    tick();
    h_sdr_rdy = 1'b0;
    checks++; if (h_rdy !== 3'b010 || h_dout !== 16'h7171) begin errors++; $display("FAIL ho_second_done: got rdy %b dout %h expected 010 7171", h_rdy, h_dout); end
    tick();
    h_req = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_cache_hit();
    test_round_robin();
    test_timeout();
    test_reset_mid_access();
    test_holdoff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
